unified_mem_arbiter: RTL and testbench

//  Shares one single-port, fixed-latency unified memory between the pipeline's

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_lat_counter.sv | 42 ++++
 rtl/unified_mem_arbiter.sv | 177 +++++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the unified memory arbiter: arbiter state encoding,
// grant owner encoding and the data word width.
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } arb_state_t;

    typedef enum logic {
        GRANT_IF  = 1'b0,
        GRANT_MEM = 1'b1
    } grant_t;

endpackage

// File: rtl/mem_lat_counter.sv
// -----------------------------------------------------------------------------
// mem_lat_counter
// Counts the remaining cycles of one memory access. Loaded with MEM_LAT-1 when
// an access is granted, decremented once per BUSY cycle; done is high when the
// count has reached zero, i.e. in the last BUSY cycle.
// Ports:
//   clk   in  clock, rising edge
//   rst   in  asynchronous active-high reset (count cleared to 0)
//   load  in  load MEM_LAT-1 (has priority over dec)
//   dec   in  decrement by one
//   done  out count is zero
// -----------------------------------------------------------------------------
module mem_lat_counter #(
    parameter int MEM_LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic done
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);

    logic [CNT_W-1:0] cnt_r;

    // Remaining-latency counter: load on grant, count down while busy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (load) begin
            cnt_r <= CNT_W'(MEM_LAT - 1);
        end else if (dec && (cnt_r != {CNT_W{1'b0}})) begin
            cnt_r <= cnt_r - CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign done = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/unified_mem_arbiter.sv
// -----------------------------------------------------------------------------
// unified_mem_arbiter
// Shares one single-port, fixed-latency memory between instruction fetch (IF)
// and the MEM stage. MEM has priority, except that after STARVE_LIM consecutive
// MEM grants with IF waiting, IF is forced to win. Each access occupies the
// memory for MEM_LAT cycles (BUSY), then a one-cycle ready pulse (DONE) is given
// to the granted port, followed by one IDLE bubble.
// Ports:
//   clk, startin            clock; asynchronous active-high reset
//   if_req/if_addr          IF read request and byte address
//   if_rdata/if_ready       fetched word and its one-cycle completion pulse
//   mem_rd/mem_wr           MEM load / store request (mutually exclusive)
//   mem_addr/mem_wdata      MEM byte address and store data
//   mem_rdata/mem_ready     load data and its one-cycle completion pulse
//   ram_en/ram_we           memory enable / write enable, high for all BUSY cycles
//   ram_addr/ram_wdata      memory word address and write data (registered)
//   ram_rdata               memory read data, valid in the last BUSY cycle
//   stall_if/stall_mem      pipeline stall requests (combinational)
// -----------------------------------------------------------------------------
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT    = 2,
    parameter int ADDR_W     = 10,
    parameter int STARVE_LIM = 3
) (
    input  logic              clk,
    input  logic              startin,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic [WORD_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [31:0]       mem_addr,
    input  logic [WORD_W-1:0] mem_wdata,
    output logic [WORD_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [WORD_W-1:0] ram_wdata,
    input  logic [WORD_W-1:0] ram_rdata,
    output logic              stall_if,
    output logic              stall_mem
);

    localparam int SC_W = $clog2(STARVE_LIM + 1);

    arb_state_t       state_r;
    grant_t           grant_r;
    logic [SC_W-1:0]  starve_cnt_r;

    logic mem_req_s;
    logic if_forced_s;
    logic take_mem_s;
    logic take_if_s;
    logic lat_load_s;
    logic lat_dec_s;
    logic lat_done_s;

    // Byte-offset and out-of-range address bits are deliberately ignored.
    logic unused_addr_bits_s;
    assign unused_addr_bits_s = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                                  mem_addr[31:ADDR_W+2], mem_addr[1:0]};

    // Arbitration decision for the current IDLE cycle
    always_comb begin
        mem_req_s   = mem_rd | mem_wr;
        if_forced_s = if_req && (starve_cnt_r == SC_W'(STARVE_LIM));
        take_mem_s  = mem_req_s && !if_forced_s;
        take_if_s   = !take_mem_s && if_req;
        if (state_r == ST_IDLE) begin
            lat_load_s = take_mem_s || take_if_s;
            lat_dec_s  = 1'b0;
        end else if (state_r == ST_BUSY) begin
            lat_load_s = 1'b0;
            lat_dec_s  = !lat_done_s;
        end else begin
            lat_load_s = 1'b0;
            lat_dec_s  = 1'b0;
        end
    end

    mem_lat_counter #(
        .MEM_LAT (MEM_LAT)
    ) u_lat_cnt (
        .clk  (clk),
        .rst  (startin),
        .load (lat_load_s),
        .dec  (lat_dec_s),
        .done (lat_done_s)
    );

    // Access sequencer: grant, starvation tracking, memory drive and data return
    always_ff @(posedge clk or posedge startin) begin
        if (startin) begin
            state_r      <= ST_IDLE;
            grant_r      <= GRANT_IF;
            starve_cnt_r <= {SC_W{1'b0}};
            if_ready     <= 1'b0;
            mem_ready    <= 1'b0;
            ram_en       <= 1'b0;
            ram_we       <= 1'b0;
            ram_addr     <= {ADDR_W{1'b0}};
            ram_wdata    <= {WORD_W{1'b0}};
            if_rdata     <= {WORD_W{1'b0}};
            mem_rdata    <= {WORD_W{1'b0}};
        end else begin
            // Ready outputs are pulses: only the BUSY exit raises them.
            if_ready  <= 1'b0;
            mem_ready <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (take_mem_s) begin
                        grant_r   <= GRANT_MEM;
                        ram_addr  <= mem_addr[ADDR_W+1:2];
                        ram_wdata <= mem_wdata;
                        ram_en    <= 1'b1;
                        ram_we    <= mem_wr;
                        state_r   <= ST_BUSY;
                        if (!if_req) begin
                            starve_cnt_r <= {SC_W{1'b0}};
                        end else if (starve_cnt_r != SC_W'(STARVE_LIM)) begin
                            starve_cnt_r <= starve_cnt_r + SC_W'(1);
                        end else begin
                            starve_cnt_r <= starve_cnt_r;
                        end
                    end else if (take_if_s) begin
                        grant_r      <= GRANT_IF;
                        ram_addr     <= if_addr[ADDR_W+1:2];
                        ram_en       <= 1'b1;
                        ram_we       <= 1'b0;
                        state_r      <= ST_BUSY;
                        starve_cnt_r <= {SC_W{1'b0}};
                    end else begin
                        // No request at all, so IF is not waiting either.
                        starve_cnt_r <= {SC_W{1'b0}};
                    end
                end
                ST_BUSY: begin
                    if (lat_done_s) begin
                        ram_en  <= 1'b0;
                        ram_we  <= 1'b0;
                        state_r <= ST_DONE;
                        if (grant_r == GRANT_MEM) begin
                            mem_ready <= 1'b1;
                            // A store leaves the load data register untouched.
                            if (!ram_we) begin
                                mem_rdata <= ram_rdata;
                            end else begin
                                mem_rdata <= mem_rdata;
                            end
                        end else begin
                            if_ready <= 1'b1;
                            if_rdata <= ram_rdata;
                        end
                    end else begin
                        state_r <= ST_BUSY;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    ram_en  <= 1'b0;
                    ram_we  <= 1'b0;
                end
            endcase
        end
    end

    assign stall_if  = if_req & ~if_ready;
    assign stall_mem = (mem_rd | mem_wr) & ~mem_ready;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_unified_mem_arbiter
// Directed scenarios followed by randomized IF/MEM traffic. A transaction-level
// reference (grant rules, fixed access window per grant, word-addressed memory
// image) predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_unified_mem_arbiter;

    localparam int MEM_LAT    = 2;
    localparam int ADDR_W     = 10;
    localparam int STARVE_LIM = 3;

    logic              clk = 1'b0;
    logic              startin;
    logic              if_req;
    logic [31:0]       if_addr;
    logic [31:0]       if_rdata;
    logic              if_ready;
    logic              mem_rd;
    logic              mem_wr;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ready;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;
    logic              stall_if;
    logic              stall_mem;

    unified_mem_arbiter #(
        .MEM_LAT    (MEM_LAT),
        .ADDR_W     (ADDR_W),
        .STARVE_LIM (STARVE_LIM)
    ) dut (
        .clk       (clk),
        .startin   (startin),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .stall_if  (stall_if),
        .stall_mem (stall_mem)
    );

    always #5 clk = ~clk;

    // Background content of a never-written word
    function automatic logic [31:0] init_word(input logic [ADDR_W-1:0] a);
        return ({22'h0, a} * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // Environment memory driven by the DUT's memory port
    logic [31:0] bram     [0:1023];
    bit          bwritten [0:1023];
    assign ram_rdata = bwritten[ram_addr] ? bram[ram_addr] : init_word(ram_addr);
    always @(posedge clk) begin
        if (ram_en && ram_we) begin
            bram[ram_addr]     <= ram_wdata;
            bwritten[ram_addr] <= 1'b1;
        end
    end

    // Reference model state
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          free_at = 0;
    int          starve = 0;
    bit          have_g = 1'b0;
    bit          g_mem, g_we;
    logic [ADDR_W-1:0] g_addr;
    logic [31:0] g_wdata, g_rdata;
    int          g_start;
    logic [31:0] ref_val [0:1023];
    bit          ref_wr  [0:1023];
    logic [31:0] exp_if_rdata = 32'h0;
    logic [31:0] exp_mem_rdata = 32'h0;
    bit          exp_if_ready = 1'b0;
    bit          exp_mem_ready = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_grant(input bit is_mem, input bit we,
                               input logic [31:0] a, input logic [31:0] wd);
        have_g  = 1'b1;
        g_mem   = is_mem;
        g_we    = we;
        g_addr  = a[ADDR_W+1:2];
        g_wdata = wd;
        g_start = cyc;
        free_at = cyc + MEM_LAT + 2;
        if (we) begin
            ref_val[g_addr] = wd;
            ref_wr[g_addr]  = 1'b1;
        end else begin
            g_rdata = ref_wr[g_addr] ? ref_val[g_addr] : init_word(g_addr);
        end
    endtask

    // Decide what the arbiter does with the inputs present in cycle cyc
    task automatic model_decide();
        bit want_mem;
        bit forced;
        want_mem = mem_rd | mem_wr;
        forced   = if_req && (starve >= STARVE_LIM);
        if (cyc >= free_at) begin
            if (want_mem && !forced) begin
                model_grant(1'b1, mem_wr, mem_addr, mem_wdata);
                starve = if_req ? ((starve < STARVE_LIM) ? starve + 1 : starve) : 0;
            end else if (if_req) begin
                model_grant(1'b0, 1'b0, if_addr, 32'h0);
                starve = 0;
            end else begin
                starve = 0;
            end
        end
    endtask

    task automatic check_cycle();
        bit en_e;
        en_e = have_g && (cyc >= g_start + 1) && (cyc <= g_start + MEM_LAT);
        exp_if_ready  = have_g && (cyc == g_start + MEM_LAT + 1) && !g_mem;
        exp_mem_ready = have_g && (cyc == g_start + MEM_LAT + 1) && g_mem;
        if (exp_if_ready) exp_if_rdata = g_rdata;
        if (exp_mem_ready && !g_we) exp_mem_rdata = g_rdata;
        chk("ram_en", {31'h0, ram_en}, {31'h0, en_e});
        chk("ram_we", {31'h0, ram_we}, {31'h0, en_e && g_we});
        if (en_e) begin
            chk("ram_addr", {22'h0, ram_addr}, {22'h0, g_addr});
            if (g_we) chk("ram_wdata", ram_wdata, g_wdata);
        end
        chk("if_ready", {31'h0, if_ready}, {31'h0, exp_if_ready});
        chk("mem_ready", {31'h0, mem_ready}, {31'h0, exp_mem_ready});
        chk("if_rdata", if_rdata, exp_if_rdata);
        chk("mem_rdata", mem_rdata, exp_mem_rdata);
        chk("stall_if", {31'h0, stall_if}, {31'h0, if_req & ~exp_if_ready});
        chk("stall_mem", {31'h0, stall_mem}, {31'h0, (mem_rd | mem_wr) & ~exp_mem_ready});
    endtask

    task automatic step();
        model_decide();
        @(posedge clk);
        #1;
        cyc++;
        check_cycle();
    endtask

    task automatic do_reset(input int n);
        startin = 1'b1;
        #1;
        chk("rst_ram_en", {31'h0, ram_en}, 32'h0);
        chk("rst_ram_we", {31'h0, ram_we}, 32'h0);
        chk("rst_if_ready", {31'h0, if_ready}, 32'h0);
        chk("rst_mem_ready", {31'h0, mem_ready}, 32'h0);
        chk("rst_ram_addr", {22'h0, ram_addr}, 32'h0);
        chk("rst_ram_wdata", ram_wdata, 32'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_mem_rdata", mem_rdata, 32'h0);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        startin       = 1'b0;
        have_g        = 1'b0;
        free_at       = cyc;
        starve        = 0;
        exp_if_rdata  = 32'h0;
        exp_mem_rdata = 32'h0;
        exp_if_ready  = 1'b0;
        exp_mem_ready = 1'b0;
    endtask

    task automatic mem_access(input bit wr, input logic [31:0] a, input logic [31:0] wd);
        mem_wr    = wr;
        mem_rd    = ~wr;
        mem_addr  = a;
        mem_wdata = wd;
        for (int i = 0; i < 10; i++) begin
            step();
            if (exp_mem_ready) break;
        end
        mem_wr = 1'b0;
        mem_rd = 1'b0;
        step();
    endtask

    logic [31:0] saved_rdata;
    int          t0, mem_rdy_cyc, if_rdy_cyc, n_rdy, pulses;
    int          order [0:3];

    initial begin
        if_req    = 1'b0;
        if_addr   = 32'h0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        startin   = 1'b1;
        do_reset(2);
        step();

        // Store 0xDEADBEEF at byte 0x20
        saved_rdata = exp_mem_rdata;
        mem_wr = 1'b1; mem_addr = 32'h20; mem_wdata = 32'hDEAD_BEEF;
        step();
        chk("st_we_1", {31'h0, ram_we}, 32'h1);
        chk("st_addr_1", {22'h0, ram_addr}, 32'd8);
        chk("st_wdata", ram_wdata, 32'hDEAD_BEEF);
        step();
        chk("st_we_2", {31'h0, ram_we}, 32'h1);
        chk("st_addr_2", {22'h0, ram_addr}, 32'd8);
        step();
        chk("st_ready", {31'h0, mem_ready}, 32'h1);
        chk("st_rdata_kept", mem_rdata, saved_rdata);
        mem_wr = 1'b0;
        step();
        step();

        // Place an instruction at byte 0x10, then fetch it
        mem_access(1'b1, 32'h10, 32'h8C01_0004);
        step();
        if_req = 1'b1; if_addr = 32'h10;
        step();
        chk("if_ram_addr", {22'h0, ram_addr}, 32'd4);
        step();
        step();
        chk("if_ready_t3", {31'h0, if_ready}, 32'h1);
        chk("if_rdata_val", if_rdata, 32'h8C01_0004);
        chk("if_stall_low", {31'h0, stall_if}, 32'h0);
        if_req = 1'b0;
        step();

        // Contention: MEM first, IF four cycles later
        if_req = 1'b1; if_addr = 32'h40;
        mem_rd = 1'b1; mem_addr = 32'h20;
        t0 = cyc; mem_rdy_cyc = -1; if_rdy_cyc = -1;
        for (int i = 0; i < 9; i++) begin
            step();
            if (mem_ready === 1'b1) mem_rdy_cyc = cyc;
            if (if_ready === 1'b1) if_rdy_cyc = cyc;
            if (if_req && !exp_if_ready) chk("cont_stall_if", {31'h0, stall_if}, 32'h1);
            if (exp_mem_ready) mem_rd = 1'b0;
            if (exp_if_ready) if_req = 1'b0;
        end
        chk("cont_mem_lat", mem_rdy_cyc - t0, 32'd3);
        chk("cont_if_gap", if_rdy_cyc - mem_rdy_cyc, 32'd4);
        chk("cont_load_data", mem_rdata, 32'hDEAD_BEEF);

        // Starvation: MEM held continuously, IF must win the fourth grant
        if_req = 1'b1; if_addr = 32'h100;
        mem_rd = 1'b1; mem_addr = 32'h200;
        n_rdy = 0;
        for (int i = 0; i < 30 && n_rdy < 4; i++) begin
            step();
            if (mem_ready === 1'b1) begin
                order[n_rdy] = 0;
                n_rdy++;
                mem_addr = mem_addr + 32'h4;
            end else if (if_ready === 1'b1) begin
                order[n_rdy] = 1;
                n_rdy++;
            end
            if (exp_if_ready) if_req = 1'b0;
        end
        mem_rd = 1'b0; if_req = 1'b0;
        step();
        step();
        chk("starve_count", n_rdy, 32'd4);
        chk("starve_g0", order[0], 32'd0);
        chk("starve_g1", order[1], 32'd0);
        chk("starve_g2", order[2], 32'd0);
        chk("starve_g3", order[3], 32'd1);

        // Request dropped one cycle into the access
        mem_rd = 1'b1; mem_addr = 32'h44;
        step();
        mem_rd = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (mem_ready === 1'b1) pulses++;
        end
        chk("drop_pulses", pulses, 32'd1);

        // Reset in the middle of a load
        mem_rd = 1'b1; mem_addr = 32'h84;
        step();
        mem_rd = 1'b0;
        do_reset(1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_rst_no_ready", {31'h0, mem_ready}, 32'h0);
        end

        // Randomized traffic from two well-behaved requesters
        for (int i = 0; i < 600; i++) begin
            if (if_req && exp_if_ready) begin
                if_req = 1'b0;
            end else if (!if_req && ($urandom_range(0, 2) == 0)) begin
                if_req  = 1'b1;
                if_addr = $urandom & 32'hFFFF_F03F;
            end
            if ((mem_rd || mem_wr) && exp_mem_ready) begin
                mem_rd = 1'b0;
                mem_wr = 1'b0;
            end else if (!(mem_rd || mem_wr) && ($urandom_range(0, 2) == 0)) begin
                if ($urandom_range(0, 1) == 1) mem_wr = 1'b1;
                else mem_rd = 1'b1;
                mem_addr  = $urandom & 32'hFFFF_F03F;
                mem_wdata = $urandom;
            end
            step();
            chk("ready_exclusive", {31'h0, if_ready & mem_ready}, 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
